// File: rtl/bus_select_encoder.sv
// Registered N-to-log2(N) request encoder with fixed-priority or round-robin
// arbitration, one-hot grant, multi-request flag, sample enable and grant lock.
module bus_select_encoder #(
  parameter int          N            = 32,
  parameter int          W            = $clog2(N),
  parameter int          RR           = 0,
  parameter logic [W-1:0] DEFAULT_CODE = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [N-1:0] req,
  input  logic         en,
  input  logic         lock,
  output logic [W-1:0] out,
  output logic [N-1:0] grant,
  output logic         valid,
  output logic         multi
);

  typedef enum logic {IDLE, GRANTED} st_t;

  localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};
  localparam logic [W:0]   N_EXT    = (W+1)'(N);
  localparam logic [W-1:0] LAST_IDX = W'(N - 1);

  st_t          st;
  logic [W-1:0] ptr;
  logic [W-1:0] win_p0;
  logic [W-1:0] ptr_nxt_p0;
  logic         multi_p0;
  logic         hold_p0;

  // First set bit at or above p, wrapping N-1 -> 0. Rotating a doubled copy
  // keeps the scan a constant-index priority chain.
  function automatic logic [W-1:0] pick(input logic [N-1:0] r, input logic [W-1:0] p);
    logic [2*N-1:0] dbl;
    logic [W-1:0]   off;
    logic [W:0]     sum;
    dbl = {r, r} >> p;
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (dbl[i]) off = W'(i);
    end
    sum = {1'b0, p} + {1'b0, off};
    if (sum >= N_EXT) sum = sum - N_EXT;
    return sum[W-1:0];
  endfunction

  // Stage 0: combinational arbitration on the sampled request vector
  always_comb begin
    win_p0     = pick(req, (RR != 0) ? ptr : '0);
    ptr_nxt_p0 = (win_p0 == LAST_IDX) ? '0 : win_p0 + 1'b1;
    multi_p0   = ($countones(req) > 1);
    hold_p0    = ((st == GRANTED) && lock) || !en;
  end

  // Stage 1: registered state and outputs
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      st    <= IDLE;
      out   <= DEFAULT_CODE;
      grant <= '0;
      valid <= 1'b0;
      multi <= 1'b0;
      ptr   <= '0;
    end else if (!hold_p0) begin
      if (req == '0) begin
        st    <= IDLE;
        out   <= DEFAULT_CODE;
        grant <= '0;
        valid <= 1'b0;
        multi <= 1'b0;
      end else begin
        st    <= GRANTED;
        out   <= win_p0;
        grant <= ONE_HOT0 << win_p0;
        valid <= 1'b1;
        multi <= multi_p0;
        ptr   <= (RR != 0) ? ptr_nxt_p0 : '0;
      end
    end
  end

endmodule

// File: tb/tb_bus_select_encoder.sv
// Scoreboard bench for bus_select_encoder: three instances (N=32 fixed priority,
// N=32 round-robin, N=6 round-robin) driven from directed vectors.
module tb_bus_select_encoder;

  typedef struct {
    logic [5:0]  out;
    logic [63:0] grant;
    logic        v;
    logic        m;
  } exp_t;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] req_a, req_b;
  logic [5:0]  req_c;
  logic        en_a, en_b, en_c;
  logic        lock_a, lock_b, lock_c;
  logic [4:0]  out_a, out_b;
  logic [2:0]  out_c;
  logic [31:0] grant_a, grant_b;
  logic [5:0]  grant_c;
  logic        valid_a, valid_b, valid_c;
  logic        multi_a, multi_b, multi_c;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t qa[$], qb[$], qc[$];
  exp_t ea, eb, ec;

  always #5 clk = ~clk;

  bus_select_encoder #(.N(32), .RR(0)) dut_a (
    .clk(clk), .clr(clr), .req(req_a), .en(en_a), .lock(lock_a),
    .out(out_a), .grant(grant_a), .valid(valid_a), .multi(multi_a));

  bus_select_encoder #(.N(32), .RR(1)) dut_b (
    .clk(clk), .clr(clr), .req(req_b), .en(en_b), .lock(lock_b),
    .out(out_b), .grant(grant_b), .valid(valid_b), .multi(multi_b));

  bus_select_encoder #(.N(6), .RR(1)) dut_c (
    .clk(clk), .clr(clr), .req(req_c), .en(en_c), .lock(lock_c),
    .out(out_c), .grant(grant_c), .valid(valid_c), .multi(multi_c));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cmp(input string tag, input logic [63:0] o, input logic [63:0] g,
                     input logic v, input logic m, input exp_t e);
    chk({tag, ".out"},   o,       64'(e.out));
    chk({tag, ".grant"}, g,       e.grant);
    chk({tag, ".valid"}, 64'(v),  64'(e.v));
    chk({tag, ".multi"}, 64'(m),  64'(e.m));
  endtask

  // Monitors: one expected record per sampled edge, popped just after the edge
  always @(posedge clk) begin
    #1;
    if (qa.size() != 0) begin
      ea = qa.pop_front();
      cmp("A", 64'(out_a), 64'(grant_a), valid_a, multi_a, ea);
    end
  end

  always @(posedge clk) begin
    #1;
    if (qb.size() != 0) begin
      eb = qb.pop_front();
      cmp("B", 64'(out_b), 64'(grant_b), valid_b, multi_b, eb);
    end
  end

  always @(posedge clk) begin
    #1;
    if (qc.size() != 0) begin
      ec = qc.pop_front();
      cmp("C", 64'(out_c), 64'(grant_c), valid_c, multi_c, ec);
    end
  end

  task automatic step_a(input logic [31:0] r, input logic e, input logic l,
                        input logic [4:0] o, input logic [31:0] g, input logic v, input logic m);
    @(negedge clk);
    req_a = r; en_a = e; lock_a = l;
    qa.push_back('{out: 6'(o), grant: 64'(g), v: v, m: m});
  endtask

  task automatic step_b(input logic [31:0] r, input logic e, input logic l,
                        input logic [4:0] o, input logic [31:0] g, input logic v, input logic m);
    @(negedge clk);
    req_b = r; en_b = e; lock_b = l;
    qb.push_back('{out: 6'(o), grant: 64'(g), v: v, m: m});
  endtask

  task automatic step_c(input logic [5:0] r, input logic e, input logic l,
                        input logic [2:0] o, input logic [5:0] g, input logic v, input logic m);
    @(negedge clk);
    req_c = r; en_c = e; lock_c = l;
    qc.push_back('{out: 6'(o), grant: 64'(g), v: v, m: m});
  endtask

  task automatic park();
    @(negedge clk);
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    lock_a = 1'b0; lock_b = 1'b0; lock_c = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clr = 1'b0;
    req_a = '0; req_b = '0; req_c = '0;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    lock_a = 1'b0; lock_b = 1'b0; lock_c = 1'b0;
    #1 clr = 1'b1;
    #2;
    chk("rst.A.out",   64'(out_a),   64'h1F);
    chk("rst.A.grant", 64'(grant_a), 64'h0);
    chk("rst.A.valid", 64'(valid_a), 64'h0);
    chk("rst.A.multi", 64'(multi_a), 64'h0);
    chk("rst.C.out",   64'(out_c),   64'h7);
    chk("rst.C.grant", 64'(grant_c), 64'h0);
    @(negedge clk);
    clr = 1'b0;

    // Full one-hot sweep, fixed priority
    for (int k = 0; k < 32; k++)
      step_a(32'h1 << k, 1'b1, 1'b0, 5'(k), 32'h1 << k, 1'b1, 1'b0);

    // Multi-request resolves to lowest index, then empty request
    step_a(32'h8000_0006, 1'b1, 1'b0, 5'd1,  32'h2, 1'b1, 1'b1);
    step_a(32'h0,         1'b1, 1'b0, 5'h1F, 32'h0, 1'b0, 1'b0);

    // Lock holds an acquired grant, release re-evaluates
    step_a(32'h8, 1'b1, 1'b0, 5'd3, 32'h8, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++)
      step_a(32'h1, 1'b1, 1'b1, 5'd3, 32'h8, 1'b1, 1'b0);
    step_a(32'h1, 1'b1, 1'b0, 5'd0, 32'h1, 1'b1, 1'b0);

    // Enable low freezes outputs
    step_a(32'h4, 1'b0, 1'b0, 5'd0, 32'h1, 1'b1, 1'b0);
    step_a(32'h0, 1'b0, 1'b0, 5'd0, 32'h1, 1'b1, 1'b0);
    step_a(32'h0, 1'b1, 1'b0, 5'h1F, 32'h0, 1'b0, 1'b0);

    // Lock in IDLE does not block acquisition; holding starts next edge
    step_a(32'h4, 1'b1, 1'b1, 5'd2,  32'h4, 1'b1, 1'b0);
    step_a(32'h1, 1'b1, 1'b1, 5'd2,  32'h4, 1'b1, 1'b0);
    step_a(32'h0, 1'b1, 1'b0, 5'h1F, 32'h0, 1'b0, 1'b0);
    park();

    // Round-robin N=32 with requests at 0, 4, 31
    step_b(32'h8000_0011, 1'b1, 1'b0, 5'd0,  32'h1,         1'b1, 1'b1);
    step_b(32'h8000_0011, 1'b1, 1'b0, 5'd4,  32'h10,        1'b1, 1'b1);
    step_b(32'h8000_0011, 1'b1, 1'b0, 5'd31, 32'h8000_0000, 1'b1, 1'b1);
    step_b(32'h8000_0011, 1'b1, 1'b0, 5'd0,  32'h1,         1'b1, 1'b1);
    park();

    // Round-robin N=6, pointer wraps after index 5
    step_c(6'b100001, 1'b1, 1'b0, 3'd0, 6'b000001, 1'b1, 1'b1);
    step_c(6'b100001, 1'b1, 1'b0, 3'd5, 6'b100000, 1'b1, 1'b1);
    step_c(6'b100001, 1'b1, 1'b0, 3'd0, 6'b000001, 1'b1, 1'b1);
    park();

    // Asynchronous clear in the middle of a locked grant
    step_b(32'h10,        1'b1, 1'b0, 5'd4, 32'h10, 1'b1, 1'b0);
    step_b(32'h8000_0011, 1'b1, 1'b1, 5'd4, 32'h10, 1'b1, 1'b0);
    @(posedge clk);
    #3;
    clr  = 1'b1;
    en_b = 1'b0;
    #1;
    chk("rst_mid.B.out",   64'(out_b),   64'h1F);
    chk("rst_mid.B.grant", 64'(grant_b), 64'h0);
    chk("rst_mid.B.valid", 64'(valid_b), 64'h0);
    chk("rst_mid.B.multi", 64'(multi_b), 64'h0);
    @(negedge clk);
    clr = 1'b0;
    step_b(32'h8000_0011, 1'b1, 1'b1, 5'd0, 32'h1,  1'b1, 1'b1);
    step_b(32'h10,        1'b1, 1'b1, 5'd0, 32'h1,  1'b1, 1'b1);
    step_b(32'h10,        1'b1, 1'b0, 5'd4, 32'h10, 1'b1, 1'b0);
    park();

    @(negedge clk);
    @(negedge clk);
    chk("drain.qa", 64'(qa.size()), 64'h0);
    chk("drain.qb", 64'(qb.size()), 64'h0);
    chk("drain.qc", 64'(qc.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_select_encoder.md
# bus_select_encoder

Parametrised, registered N-to-log2(N) request encoder for the datapath bus-select path. It generalises the fixed 32-to-5 one-hot encoder in three ways:
- accepts any request pattern, not just one-hot;
- resolves multiple requests by fixed priority or round-robin;
- adds a valid flag, a one-hot grant vector and a multi-request flag.

It also adds a sample enable and a lock that freezes the current selection while a bus transfer is in progress.

## Interface
- N, 32, number of request inputs (2..64)
- W, $clog2(N), width of encoded output
- RR, 0, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin
- DEFAULT_CODE, {W{1'b1}}, code driven on `out` when no request is granted
- clk  input  1  rising-edge clock
- clr  input  1  asynchronous, active-high reset
- req  input  N  request vector, any number of bits may be set
- en  input  1  sample enable; when 0, all state holds
- lock  input  1  hold current grant while in GRANTED
- out  output  W  registered encoded index of winner
- grant  output  N  registered one-hot of winner
- valid  output  1  registered, 1 when `out`/`grant` reflect a real request
- multi  output  1  registered, 1 when more than one `req` bit was set at the sampled edge

## Operation
- State: `st` ∈ {IDLE, GRANTED}; round-robin pointer `ptr` [W-1:0], used only when RR=1 and tied to 0 otherwise.
- Reset (clr=1, asynchronous, any time, including mid-lock):
  - st=IDLE, out=DEFAULT_CODE, grant=0, valid=0, multi=0, ptr=0.
- Winner selection:
  - RR=0: lowest set index of `req`.
  - RR=1: first set index scanning upward from `ptr`, wrapping N-1 → 0.
- Each rising clk edge, in order of precedence:
  - st=GRANTED and lock=1: hold everything. Ignores `en` and `req`.
  - en=0: hold everything.
  - req=0: st←IDLE, out←DEFAULT_CODE, grant←0, valid←0, multi←0. `ptr` unchanged.
  - Otherwise:
    - st←GRANTED, out←winner, grant←(1<<winner), valid←1.
    - multi←(popcount(req)>1).
    - RR=1: ptr←(winner+1) mod N. For N not a power of 2, winner=N-1 gives ptr=0.
- Lock behaviour:
  - lock=1 in IDLE does not block acquisition. The edge that acquires a request follows the normal rule; holding starts the following edge.
  - Lock released (lock=0 with en=1): the next edge re-evaluates `req` normally.
- Width rules:
  - `out` is the zero-extended winner index in W bits.
  - DEFAULT_CODE may equal a legal index (e.g. 31 for N=32). Consumers qualify `out` with `valid`.
- `grant` is always zero or exactly one-hot, and consistent with `out` whenever valid=1.
- `req` bits beyond N do not exist. No X-propagation: an all-zero `req` is a defined case.

## Timing
- Latency: 1 cycle from `req` sampled at edge k to `out`/`grant`/`valid`/`multi` visible after edge k.
- All outputs come directly from flops; no combinational path from `req`, `en` or `lock` to outputs.
- Round-robin fairness: with a request held continuously, it is granted at least once every N sampled edges.
- Asynchronous clr takes effect immediately, without waiting for an edge. Deassertion is assumed synchronised upstream. The first evaluation is the first rising edge after clr falls.
- `en` and `lock` sampled at the same edge as `req`. Simultaneous lock=1 and en=0 in GRANTED: hold (identical result).

## Test plan
- Reset: assert clr mid-cycle with N=32 → immediately out=5'h1F, grant=0, valid=0, multi=0. Repeat during a locked grant; ptr returns to 0, so the next RR grant starts from index 0.
- Full index sweep, RR=0, N=32: drive req=1<<k for k=0..31 with en=1 → one edge later out=k, grant=1<<k, valid=1, multi=0. Covers k=12..31, which must encode correctly.
- Fixed priority multi-request: req=32'h8000_0006 → out=1, grant=32'h2, multi=1. Then req=0 → out=5'h1F, valid=0.
- Round-robin, RR=1, N=32: hold req=32'h8000_0011 for 4 edges → out sequence 0, 4, 31, 0; ptr after the third grant wraps to 0.
- Round-robin, N=6, RR=1: req=6'b100001 → out 0, 5, 0.
- Lock: acquire req=32'h8 (out=3), then lock=1 and req=32'h1 for 5 edges → out stays 3, valid=1. Drop lock → the next edge gives out=0. Separately, en=0 with changing req → outputs unchanged.
